// File: rtl/mem_ctrl.sv
// Memory access controller: buffers CPU requests in a small FIFO and holds each
// one on the RAM port for WAIT_CYCLES clocks so the slower RAM clock can sample it.
//
// state  | meaning
// IDLE   | mem_en low; pops the FIFO head when one is available
// ACCESS | mem_en high; request held on the RAM port until the timer expires
module mem_ctrl #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 4,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = 1 + ADDR_W + DATA_W;

    localparam logic [3:0]       WAIT_LOAD = 4'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    logic              head_rw;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        timer;
    logic [3:0]        timer_nxt;
    logic              mem_en_nxt;
    logic              mem_rw_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;
    logic              rsp_valid_nxt;
    logic [DATA_W-1:0] rsp_rdata_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign fifo_full  = (fifo_cnt == FULL_CNT);
    assign fifo_empty = (fifo_cnt == '0);
    assign req_ready  = !fifo_full;
    assign push       = req_valid && !fifo_full;
    assign busy       = (state != IDLE) || !fifo_empty;

    assign {head_rw, head_addr, head_wdata} = fifo_mem[rd_ptr];

    // Storage carries no reset; validity is tracked entirely by fifo_cnt.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {req_rw, req_addr, req_wdata};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        mem_en_nxt    = mem_en;
        mem_rw_nxt    = mem_rw;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        rsp_valid_nxt = 1'b0;
        rsp_rdata_nxt = rsp_rdata;
        pop           = 1'b0;

        unique case (state)
            IDLE: begin
                mem_en_nxt = 1'b0;
                if (!fifo_empty) begin
                    pop           = 1'b1;
                    mem_rw_nxt    = head_rw;
                    mem_addr_nxt  = head_addr;
                    mem_wdata_nxt = head_wdata;
                    timer_nxt     = WAIT_LOAD;
                    mem_en_nxt    = 1'b1;
                    state_nxt     = ACCESS;
                end
            end
            ACCESS: begin
                if (timer != 4'd0) begin
                    timer_nxt = timer - 4'd1;
                end else begin
                    // Terminal count: RAM has had WAIT_CYCLES clocks to settle Q.
                    mem_en_nxt = 1'b0;
                    state_nxt  = IDLE;
                    if (mem_rw) begin
                        rsp_rdata_nxt = mem_q;
                        rsp_valid_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt  = IDLE;
                mem_en_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= 4'd0;
            mem_en    <= 1'b0;
            mem_rw    <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            mem_en    <= mem_en_nxt;
            mem_rw    <= mem_rw_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: two instances (WAIT_CYCLES 4 and 1) each with a RAM model,
// checked every cycle against a transaction-level timing model.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_rw    [2];
    logic [3:0]  req_addr  [2];
    logic [15:0] req_wdata [2];
    logic        rsp_valid [2];
    logic [15:0] rsp_rdata [2];
    logic        busy      [2];
    logic        mem_en    [2];
    logic        mem_rw    [2];
    logic [3:0]  mem_addr  [2];
    logic [15:0] mem_wdata [2];
    logic [15:0] mem_q     [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    mem_ctrl #(.ADDR_W(4), .DATA_W(16), .WAIT_CYCLES(4), .FIFO_DEPTH(2)) u_dut_w4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_rw(req_rw[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
        .mem_en(mem_en[0]), .mem_rw(mem_rw[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_q(mem_q[0])
    );

    mem_ctrl #(.ADDR_W(4), .DATA_W(16), .WAIT_CYCLES(1), .FIFO_DEPTH(2)) u_dut_w1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_rw(req_rw[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
        .mem_en(mem_en[1]), .mem_rw(mem_rw[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_q(mem_q[1])
    );

    typedef struct packed {
        logic        rw;
        logic [3:0]  addr;
        logic [15:0] wdata;
    } req_t;

    for (genvar g = 0; g < 2; g++) begin : g_mon
        localparam int W = (g == 0) ? 4 : 1;

        logic [15:0] ram     [16];
        logic [15:0] ref_mem [16];

        req_t        pend [$];
        req_t        cur;
        bit          active;
        longint      cyc;
        longint      end_cyc;
        bit          exp_rsp_v;
        logic [15:0] exp_rdata;

        // RAM block: writes land while en is held, Q follows addr.
        always @(posedge clk) begin
            if (mem_en[g] && !mem_rw[g]) ram[mem_addr[g]] <= mem_wdata[g];
        end
        assign mem_q[g] = ram[mem_addr[g]];

        task automatic model_reset();
            pend.delete();
            cur       = '{rw: 1'b1, addr: 4'd0, wdata: 16'd0};
            active    = 1'b0;
            end_cyc   = 0;
            exp_rsp_v = 1'b0;
            exp_rdata = 16'd0;
        endtask

        // Reference: an access occupies W cycles, then at least one idle
        // cycle precedes the next pop; requests leave in arrival order.
        initial begin
            for (int i = 0; i < 16; i++) begin
                ram[i]     = 16'd0;
                ref_mem[i] = 16'd0;
            end
            cyc = 0;
            model_reset();
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    model_reset();
                end else begin
                    bit acc;
                    acc       = req_valid[g] && (pend.size() < 2);
                    cyc++;
                    exp_rsp_v = 1'b0;
                    if (active && cyc == end_cyc) begin
                        active = 1'b0;
                        if (cur.rw) begin
                            exp_rsp_v = 1'b1;
                            exp_rdata = ref_mem[cur.addr];
                        end
                    end else if (!active && pend.size() > 0) begin
                        cur     = pend.pop_front();
                        active  = 1'b1;
                        end_cyc = cyc + W;
                        if (!cur.rw) ref_mem[cur.addr] = cur.wdata;
                    end
                    if (acc) pend.push_back('{rw: req_rw[g], addr: req_addr[g], wdata: req_wdata[g]});
                end
            end
        end

        always @(negedge clk) begin
            if (rst_n) begin
                check($sformatf("u%0d.req_ready", g), 32'(req_ready[g]), 32'(pend.size() < 2));
                check($sformatf("u%0d.busy", g),      32'(busy[g]),      32'(active || pend.size() > 0));
                check($sformatf("u%0d.mem_en", g),    32'(mem_en[g]),    32'(active));
                check($sformatf("u%0d.mem_rw", g),    32'(mem_rw[g]),    32'(cur.rw));
                check($sformatf("u%0d.mem_addr", g),  32'(mem_addr[g]),  32'(cur.addr));
                check($sformatf("u%0d.mem_wdata", g), 32'(mem_wdata[g]), 32'(cur.wdata));
                check($sformatf("u%0d.rsp_valid", g), 32'(rsp_valid[g]), 32'(exp_rsp_v));
                check($sformatf("u%0d.rsp_rdata", g), 32'(rsp_rdata[g]), 32'(exp_rdata));
            end
        end
    end

    // Returns at the negedge before the accepting edge.
    task automatic send(input int i, input logic rw, input logic [3:0] a, input logic [15:0] d);
        int n = 0;
        @(negedge clk);
        req_valid[i] = 1'b1;
        req_rw[i]    = rw;
        req_addr[i]  = a;
        req_wdata[i] = d;
        while (!req_ready[i]) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                check("send_wait_ready", 32'(req_ready[i]), 32'd1);
                break;
            end
        end
    endtask

    task automatic idle(input int i, input int cycles);
        @(negedge clk);
        req_valid[i] = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic drain(input int i);
        int n = 0;
        while (busy[i] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("u%0d.drain_busy", i), 32'(busy[i]), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_rw[i]    = 1'b0;
            req_addr[i]  = 4'd0;
            req_wdata[i] = 16'd0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single write, then read back
        send(0, 1'b0, 4'd3, 16'hBEEF);
        idle(0, 8);
        send(0, 1'b1, 4'd3, 16'h0000);
        idle(0, 8);
        check("raw_rdata", 32'(rsp_rdata[0]), 32'h0000_BEEF);

        // FIFO fill behind an access already in flight
        send(0, 1'b0, 4'd5, 16'h1111);
        send(0, 1'b0, 4'd6, 16'h2222);
        send(0, 1'b1, 4'd5, 16'h0000);
        send(0, 1'b1, 4'd6, 16'h0000);
        idle(0, 0);
        drain(0);
        check("fill_last_rdata", 32'(rsp_rdata[0]), 32'h0000_2222);

        // reset in the 2nd ACCESS cycle of a read, one request queued
        send(0, 1'b1, 4'd6, 16'h0000);
        send(0, 1'b0, 4'd7, 16'h7777);
        idle(0, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mem_en",    32'(mem_en[0]),    32'd0);
        check("rst_req_ready", 32'(req_ready[0]), 32'd1);
        check("rst_busy",      32'(busy[0]),      32'd0);
        check("rst_mem_rw",    32'(mem_rw[0]),    32'd1);
        check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("rst_mem_addr",  32'(mem_addr[0]),  32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_rst_busy", 32'(busy[0]), 32'd0);

        // randomized traffic at WAIT_CYCLES = 4
        for (int k = 0; k < 80; k++) begin
            int gap;
            send(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom));
            gap = $urandom_range(0, 3);
            if (gap > 0) idle(0, gap - 1);
        end
        idle(0, 0);
        drain(0);

        // alternating write/read at WAIT_CYCLES = 1
        for (int k = 0; k < 40; k++) begin
            logic [3:0] a;
            a = 4'($urandom_range(0, 15));
            send(1, 1'b0, a, 16'($urandom));
            send(1, 1'b1, a, 16'h0000);
            if ($urandom_range(0, 3) == 0) idle(1, $urandom_range(0, 2));
        end
        idle(1, 0);
        drain(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory access controller between the CPU datapath and the 16-bit RAM block. It accepts read and write requests through a valid/ready handshake and buffers up to two of them in a small FIFO. Each request is driven onto the RAM's `en`/`rw`/`addr`/`A` port and held stable for a fixed number of cycles, so that the RAM, which runs on its own internally generated clock, is guaranteed to sample it. For reads, `Q` is captured and returned with a one-cycle response pulse.

## Interface
- `ADDR_W`, 4: address width; matches the RAM `addr` port.
- `DATA_W`, 16: data width.
- `WAIT_CYCLES`, 4: `clk` cycles `mem_en` is held per access; legal range 1..15.
- `FIFO_DEPTH`, 2: request FIFO entries; power of two.
- `clk`, in, 1: system clock; all state updates on rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, 1: requester has a request.
- `req_ready`, out, 1: FIFO can accept; equals `!fifo_full`.
- `req_rw`, in, 1: 1 = read, 0 = write (same polarity as RAM `rw`).
- `req_addr`, in, `ADDR_W`: target address.
- `req_wdata`, in, `DATA_W`: write data; ignored for reads.
- `rsp_valid`, out, 1: one-cycle pulse; `rsp_rdata` is valid.
- `rsp_rdata`, out, `DATA_W`: read data; holds its value until the next read response.
- `busy`, out, 1: FIFO non-empty or FSM not IDLE.
- `mem_en`, out, 1: drives RAM `en`.
- `mem_rw`, out, 1: drives RAM `rw`.
- `mem_addr`, out, `ADDR_W`: drives RAM `addr`.
- `mem_wdata`, out, `DATA_W`: drives RAM `A`.
- `mem_q`, in, `DATA_W`: from RAM `Q`.

## Operation
- **Accept.** A request is accepted on any rising edge with `req_valid && req_ready`. The accepted request `{rw, addr, wdata}` is pushed into the FIFO.
- **Back-pressure.** `req_valid` while `req_ready` is low is ignored. The requester must hold the request.
- **FIFO.** There is no bypass: a push into an empty FIFO cannot be popped on the same edge. A simultaneous push and pop leaves the count unchanged. Pointers wrap modulo `FIFO_DEPTH`.
- **IDLE state.**
  - `mem_en` = 0.
  - If the FIFO is non-empty: pop the head and load `mem_rw`/`mem_addr`/`mem_wdata`.
  - Load the counter with `WAIT_CYCLES-1`, set `mem_en` = 1, and go to ACCESS.
- **ACCESS state.**
  - `mem_en` = 1.
  - `mem_rw`, `mem_addr` and `mem_wdata` are held constant.
  - While counter ≠ 0: decrement.
  - When counter = 0:
    - `mem_en` <= 0 and the next state is IDLE.
    - If `mem_rw` = 1, also `rsp_rdata` <= `mem_q` and `rsp_valid` <= 1.
- `rsp_valid` is high for exactly one cycle: the first IDLE cycle after a read. Writes never pulse `rsp_valid`.
- `mem_rw`, `mem_addr` and `mem_wdata` keep their last values in IDLE. They change only on a pop.
- Counter width is 4 bits; no other arithmetic.
- **Reset values (asynchronous, immediate):**
  - FSM = IDLE; FIFO empty.
  - `mem_en` = 0, `mem_rw` = 1 (read), `mem_addr` = 0, `mem_wdata` = 0.
  - `rsp_valid` = 0, `rsp_rdata` = 0.
  - `req_ready` = 1, `busy` = 0.
- **Reset mid-access:** `mem_en` drops immediately. The in-flight request and all FIFO contents are discarded, and no response is issued.

## Timing
- Request accepted at edge E0 into an empty FIFO with FSM in IDLE:
  - Pop at E1.
  - `mem_en` is high from E1 to E1+`WAIT_CYCLES`, i.e. exactly `WAIT_CYCLES` cycles.
  - For a read, `rsp_valid` is high for the cycle following edge E1+`WAIT_CYCLES`.
  - Read latency from the acceptance edge is `WAIT_CYCLES`+1 cycles (5 at default).
- **Back-to-back requests:** the next pop occurs on the edge ending the first IDLE cycle. `mem_en` is therefore low for exactly one cycle between accesses.
- **Throughput:** one access per `WAIT_CYCLES`+1 cycles.
- `mem_q` is sampled only on the final ACCESS edge. The RAM must have produced `Q` within `WAIT_CYCLES` cycles.
- `req_ready` reflects the FIFO count registered at the previous edge. A pop does not raise `req_ready` combinationally in the same cycle.
- `busy` is combinational from state and FIFO count.

## Test plan
- **Reset values:** assert `rst_n` = 0 mid-run, then release.
  - Outputs take their reset values immediately.
  - `req_ready` = 1, `busy` = 0, `mem_en` = 0, `mem_rw` = 1.
- **Single write:** write addr 3, data 0xBEEF.
  - `mem_en` is high for 4 cycles starting one cycle after acceptance, with `mem_rw` = 0, `mem_addr` = 3 and `mem_wdata` = 0xBEEF held stable.
  - No `rsp_valid`.
- **Read after write:** write 0xBEEF to addr 3, then read addr 3.
  - `rsp_valid` pulses for one cycle with `rsp_rdata` = 0xBEEF, 5 cycles after the read is accepted.
- **FIFO fill:** drive three requests on consecutive cycles while the FSM is busy.
  - `req_ready` falls after two accepts, so the third is held.
  - Accesses occur in order, with exactly one `mem_en`-low cycle between them.
  - `busy` drops only after the last access completes.
- **Reset mid-access:** pull `rst_n` low in the 2nd ACCESS cycle of a read with one request queued.
  - `mem_en` falls immediately and no `rsp_valid` occurs.
  - After release, the FIFO is empty and `busy` = 0.
- **Minimum wait:** with `WAIT_CYCLES` = 1, issue alternating read/write requests.
  - `mem_en` is high for 1 cycle per access.
  - Read data matches the previously written values.
